// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-port arbiter in front of the 4K x 12-bit
// asynchronous (2114-style) memory unit: default geometry and access-cycle
// count, sequencer state encoding, and port identifiers used by the selector.
// Optional build macro used by the selector: MEM_ARB_RR_EN (round-robin).
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int ACC_CYC_DEF = 4;   // cycles covering the memory access time
    localparam int AW_DEF      = 12;  // address width
    localparam int DW_DEF      = 12;  // data width
    localparam int CNT_W       = 4;   // holds ACC_CYC values 1..15

    // Port identifiers; the grant is carried as a single "B granted" bit.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } state_e;

endpackage

// File: rtl/mem_arb_sel.sv
// -----------------------------------------------------------------------------
// mem_arb_sel
// Grant selector for mem_arbiter. Combinationally picks which pending request
// is served when the sequencer is idle.
//   Default build     : fixed priority, port A over port B.
//   MEM_ARB_RR_EN set : round-robin; a 1-bit last-served pointer favours the
//                       port that was not served last. The pointer resets to
//                       "B served" so A wins the first tie.
// Ports:
//   clk, srst  - clock and synchronous active-high reset (pointer only)
//   req_a/b    - pending requests
//   take       - the sequencer accepted the grant this cycle
//   gnt_valid  - at least one request pending
//   gnt_b      - 1 = grant port B, 0 = grant port A
// -----------------------------------------------------------------------------
module mem_arb_sel
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    output logic gnt_valid,
    output logic gnt_b
);

    assign gnt_valid = req_a | req_b;

`ifdef MEM_ARB_RR_EN
    logic last_b_q;
    logic last_b_d;

    always_comb begin
        // B wins when it is alone, or on a tie when A was served last.
        gnt_b    = req_b & (~req_a | (last_b_q != PORT_B));
        last_b_d = last_b_q;
        if (take) begin
            last_b_d = gnt_b;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            last_b_q <= PORT_B;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`else
    assign gnt_b = req_b & ~req_a;

    // Clock, reset and take only feed the round-robin pointer.
    logic unused_sel;
    assign unused_sel = ^{clk, srst, take};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one 4K x 12-bit asynchronous memory between port A (CPU) and port B
// (front panel / I/O). A level request held until its one-cycle ack is turned
// into a chip-select / write-enable sequence that covers the memory's access
// time and its delayed deselect:
//   IDLE -> SETUP -> ACCESS (ACC_CYC) -> [HOLD, writes] -> RECOVER (ACC_CYC)
// Read ack arrives ACC_CYC+2 cycles after the sampling IDLE cycle, write ack
// ACC_CYC+3. Reset lands in RECOVER so a select still active inside the
// memory drains before the first grant.
// Build macro: MEM_ARB_RR_EN selects round-robin arbitration (see mem_arb_sel).
// Ports:
//   iCLK, iRST                        clock, synchronous active-high reset
//   iREQx/iWRx/iADDRx/iWDATAx, oACKx  requester handshakes, x = A, B
//   oRDATA                            read data, valid in the ack cycle, held
//   oBUSY                             high whenever not in IDLE
//   oMADDR/oMDATA/iMDATA              memory address, data-in, data-out
//   oMCSELn, oMWR_ENn                 memory chip select / write enable (low)
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ACC_CYC = ACC_CYC_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iREQA,
    input  logic          iWRA,
    input  logic [AW-1:0] iADDRA,
    input  logic [DW-1:0] iWDATAA,
    output logic          oACKA,
    input  logic          iREQB,
    input  logic          iWRB,
    input  logic [AW-1:0] iADDRB,
    input  logic [DW-1:0] iWDATAB,
    output logic          oACKB,
    output logic [DW-1:0] oRDATA,
    output logic          oBUSY,
    output logic [AW-1:0] oMADDR,
    output logic [DW-1:0] oMDATA,
    input  logic [DW-1:0] iMDATA,
    output logic          oMCSELn,
    output logic          oMWR_ENn
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cs_n_q, cs_n_d;
    logic             wr_n_q, wr_n_d;
    logic [AW-1:0]    maddr_q, maddr_d;
    logic [DW-1:0]    mdata_q, mdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             wr_q, wr_d;         // latched direction of the access
    logic             gnt_b_q, gnt_b_d;   // latched granted port
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic             busy_q, busy_d;

    logic             sel_valid;
    logic             sel_b;
    logic             take;

    mem_arb_sel u_sel (
        .clk       (iCLK),
        .srst      (iRST),
        .req_a     (iREQA),
        .req_b     (iREQB),
        .take      (take),
        .gnt_valid (sel_valid),
        .gnt_b     (sel_b)
    );

    // Output registers are computed for the state being entered, so every
    // memory control line comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        wr_n_d  = wr_n_q;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        gnt_b_d = gnt_b_q;
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
        take    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cs_n_d = 1'b1;
                wr_n_d = 1'b1;
                if (sel_valid) begin
                    take    = 1'b1;
                    gnt_b_d = sel_b;
                    maddr_d = sel_b ? iADDRB : iADDRA;
                    mdata_d = sel_b ? iWDATAB : iWDATAA;
                    wr_d    = sel_b ? iWRB : iWRA;
                    cs_n_d  = 1'b0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Address has settled for a cycle; only now open the write.
                cs_n_d  = 1'b0;
                wr_n_d  = ~wr_q;
                cnt_d   = CNT_LOAD;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_ONE) begin
                    if (wr_q) begin
                        // Close the write while select, address and data stay put.
                        wr_n_d  = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        rdata_d = iMDATA;
                        cs_n_d  = 1'b1;
                        cnt_d   = CNT_LOAD;
                        ack_a_d = (gnt_b_q == PORT_A);
                        ack_b_d = (gnt_b_q == PORT_B);
                        state_d = ST_RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                cs_n_d  = 1'b1;
                cnt_d   = CNT_LOAD;
                ack_a_d = (gnt_b_q == PORT_A);
                ack_b_d = (gnt_b_q == PORT_B);
                state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                // The memory's internal select lags oMCSELn; wait it out.
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                cnt_d   = CNT_LOAD;
                state_d = ST_RECOVER;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_RECOVER;
            cnt_q   <= CNT_LOAD;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            maddr_q <= '0;
            mdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            gnt_b_q <= PORT_A;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            gnt_b_q <= gnt_b_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            busy_q  <= busy_d;
        end
    end

    assign oMCSELn  = cs_n_q;
    assign oMWR_ENn = wr_n_q;
    assign oMADDR   = maddr_q;
    assign oMDATA   = mdata_q;
    assign oRDATA   = rdata_q;
    assign oACKA    = ack_a_q;
    assign oACKB    = ack_b_q;
    assign oBUSY    = busy_q;

endmodule
